// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store sequencer over a word-wide datamem.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    output logic              o_req_ready,
    input  logic              i_is_store,
    input  logic [1:0]        i_size,
    input  logic              i_is_unsigned,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic [31:0]       o_mem_wd,
    output logic              o_mem_we,
    input  logic [31:0]       i_mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-3:0] LP_WORDS = (ADDR_W-2)'(MEM_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic [1:0]        r_size_q;
    logic              r_store_q;
    logic              r_uns_q;
    logic [31:0]       r_wdata_q;
    logic [31:0]       r_word_q;
    logic              r_err_q;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_fault;
    logic [ADDR_W-1:0] w_addr_eff;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic [31:0]       w_merge;

    assign w_accept = (r_state == S_IDLE) && i_req;

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((i_size == 2'd1) && i_addr[0]) ||
                        ((i_size == 2'd2) && (i_addr[1:0] != 2'b00));
    assign w_addr_eff = i_addr;
    assign w_fault    = (i_size == 2'd3) ||
                        (i_addr[ADDR_W-1:2] >= LP_WORDS) ||
                        w_misalign;
`else
    always_comb begin
        w_addr_eff = i_addr;
        if (i_size == 2'd1)
            w_addr_eff[0] = 1'b0;
        else if (i_size == 2'd2)
            w_addr_eff[1:0] = 2'b00;
    end
    assign w_fault = (i_size == 2'd3) ||
                     (i_addr[ADDR_W-1:2] >= LP_WORDS);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_req) w_next = w_fault ? S_DONE : S_RD;
            S_RD:    w_next = r_store_q ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and write strobe come from state alone, never from i_req.
    always_comb begin
        o_req_ready = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        o_mem_we    = 1'b0;
        unique case (r_state)
            S_IDLE:  o_req_ready = 1'b1;
            S_RD:    ;
            S_WR:    o_mem_we = 1'b1;
            S_DONE: begin
                o_done = 1'b1;
                o_err  = r_err_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (r_addr_q[1:0])
            2'd0:    w_byte = i_mem_rd[7:0];
            2'd1:    w_byte = i_mem_rd[15:8];
            2'd2:    w_byte = i_mem_rd[23:16];
            default: w_byte = i_mem_rd[31:24];
        endcase
        w_half = r_addr_q[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
        unique case (r_size_q)
            2'd0:    w_ext = {{24{~r_uns_q & w_byte[7]}}, w_byte};
            2'd1:    w_ext = {{16{~r_uns_q & w_half[15]}}, w_half};
            default: w_ext = i_mem_rd;
        endcase
    end

    always_comb begin
        w_merge = r_word_q;
        unique case (r_size_q)
            2'd0: begin
                unique case (r_addr_q[1:0])
                    2'd0:    w_merge[7:0]   = r_wdata_q[7:0];
                    2'd1:    w_merge[15:8]  = r_wdata_q[7:0];
                    2'd2:    w_merge[23:16] = r_wdata_q[7:0];
                    default: w_merge[31:24] = r_wdata_q[7:0];
                endcase
            end
            2'd1: begin
                if (r_addr_q[1])
                    w_merge[31:16] = r_wdata_q[15:0];
                else
                    w_merge[15:0] = r_wdata_q[15:0];
            end
            default: w_merge = r_wdata_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr_q  <= '0;
            r_size_q  <= 2'd0;
            r_store_q <= 1'b0;
            r_uns_q   <= 1'b0;
            r_wdata_q <= 32'h0;
            r_word_q  <= 32'h0;
            r_err_q   <= 1'b0;
            r_rdata   <= 32'h0;
        end else if (w_accept) begin
            r_addr_q  <= w_addr_eff;
            r_size_q  <= i_size;
            r_store_q <= i_is_store;
            r_uns_q   <= i_is_unsigned;
            r_wdata_q <= i_wdata;
            r_err_q   <= w_fault;
            r_rdata   <= 32'h0;
        end else if (r_state == S_RD) begin
            r_word_q <= i_mem_rd;
            if (!r_store_q)
                r_rdata <= w_ext;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_mem_a  = {r_addr_q[ADDR_W-1:2], 2'b00};
    assign o_mem_wd = w_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit
// against a byte-lane reference model of the data memory.
module tb_mem_access_unit;

    localparam int AW = 32;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          req_ready;
    logic          is_store;
    logic [1:0]    size;
    logic          is_unsigned;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic [31:0]   mem_rd;

    int n_pass  = 0;
    int n_total = 0;
    int we_cnt  = 0;
    logic [31:0] dq[$];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .MEM_WORDS(NW)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .o_req_ready(req_ready),
        .i_is_store(is_store), .i_size(size), .i_is_unsigned(is_unsigned),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_done(done),
        .o_err(err), .o_mem_a(mem_a), .o_mem_wd(mem_wd), .o_mem_we(mem_we),
        .i_mem_rd(mem_rd)
    );

    // Behavioural datamem with a backdoor port used for preloading.
    logic [31:0] mem [0:NW-1];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_data = 32'h0;

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a[7:2]] <= mem_wd;
        else if (bd_we)
            mem[bd_idx] <= bd_data;
    end

    assign mem_rd = (mem_a[AW-1:8] == '0) ? mem[mem_a[7:2]] : 32'h0;

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (done) dq.push_back(rdata);
    end

    logic [31:0] ref_mem [0:NW-1];

    function automatic void model(input logic st, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] a,
                                  input logic [31:0] wd, output logic f,
                                  output logic [31:0] rd, output int lat);
        int unsigned idx, lane, sh;
        logic [31:0] w, m, v;
        f = (sz == 2'd3) || (a / 4 >= NW);
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'd1 && a % 2 != 0) f = 1'b1;
        if (sz == 2'd2 && a % 4 != 0) f = 1'b1;
`endif
        rd = 32'h0;
        lat = 1;
        if (f) return;
        idx  = a / 4;
        lane = a % 4;
        if (sz == 2'd1) lane = (lane / 2) * 2;
        if (sz == 2'd2) lane = 0;
        sh = lane * 8;
        w  = ref_mem[idx];
        if (st) begin
            lat = 3;
            if (sz == 2'd0) m = 32'hFF;
            else if (sz == 2'd1) m = 32'hFFFF;
            else m = 32'hFFFF_FFFF;
            ref_mem[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
        end else begin
            lat = 2;
            if (sz == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (!uns && v >= 128) v = v - 256;
            end else if (sz == 2'd1) begin
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32768) v = v - 65536;
            end else begin
                v = w;
            end
            rd = v;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx[5:0];
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic do_access(input string nm, input logic st,
                             input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] o_rd, output logic o_er);
        logic        ef;
        logic [31:0] erd;
        int          elat, k, we0, idx;
        bit          got;
        model(st, sz, uns, a, wd, ef, erd, elat);
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd;
        req = 1'b1;
        we0 = we_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        k = 1;
        got = 0;
        while (k <= 8 && !got) begin
            if (done) got = 1;
            else begin
                @(posedge clk);
                #1 k++;
            end
        end
        o_rd = rdata;
        o_er = err;
        n_total++;
        if (!got || k != elat)
            $display("FAIL %s latency: got %0d (done=%0b) want %0d", nm, k, got, elat);
        else n_pass++;
        n_total++;
        if (err !== ef)
            $display("FAIL %s err: got %b want %b", nm, err, ef);
        else n_pass++;
        if (!st || ef) begin
            n_total++;
            if (rdata !== erd)
                $display("FAIL %s rdata: got %h want %h", nm, rdata, erd);
            else n_pass++;
        end
        if (ef) begin
            n_total++;
            if (we_cnt != we0)
                $display("FAIL %s fault_we: got %0d writes want 0", nm, we_cnt - we0);
            else n_pass++;
        end
        if (a / 4 < NW) begin
            idx = a / 4;
            n_total++;
            if (mem[idx] !== ref_mem[idx])
                $display("FAIL %s mem[%0d]: got %h want %h", nm, idx, mem[idx], ref_mem[idx]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_ctl: got rdy=%b done=%b err=%b want 1 0 0", req_ready, done, err);
        else n_pass++;
        n_total++;
        if (rdata !== 32'h0 || mem_we !== 1'b0)
            $display("FAIL reset_data: got rdata=%h we=%b want 0 0", rdata, mem_we);
        else n_pass++;
        n_total++;
        if (mem_a !== '0 || mem_wd !== 32'h0)
            $display("FAIL reset_mem: got a=%h wd=%h want 0 0", mem_a, mem_wd);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] r;
        logic        e;
        do_access("sw_10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, r, e);
        do_access("lw_10", 0, 2'd2, 0, 32'h10, 32'h0, r, e);
        n_total++;
        if (r !== 32'hDEADBEEF) $display("FAIL lw_const: got %h want DEADBEEF", r);
        else n_pass++;
        preload(4, 32'h11223344);
        do_access("sb_11", 1, 2'd0, 0, 32'h11, 32'h000000AA, r, e);
        n_total++;
        if (mem[4] !== 32'h1122AA44) $display("FAIL sb_const: got %h want 1122AA44", mem[4]);
        else n_pass++;
        do_access("lb_11", 0, 2'd0, 0, 32'h11, 32'h0, r, e);
        n_total++;
        if (r !== 32'hFFFFFFAA) $display("FAIL lb_const: got %h want FFFFFFAA", r);
        else n_pass++;
        do_access("lbu_11", 0, 2'd0, 1, 32'h11, 32'h0, r, e);
        n_total++;
        if (r !== 32'h000000AA) $display("FAIL lbu_const: got %h want 000000AA", r);
        else n_pass++;
        do_access("sh_12", 1, 2'd1, 0, 32'h12, 32'h00008001, r, e);
        n_total++;
        if (mem[4] !== 32'h8001AA44) $display("FAIL sh_const: got %h want 8001AA44", mem[4]);
        else n_pass++;
        do_access("lh_12", 0, 2'd1, 0, 32'h12, 32'h0, r, e);
        n_total++;
        if (r !== 32'hFFFF8001) $display("FAIL lh_const: got %h want FFFF8001", r);
        else n_pass++;
        do_access("lhu_12", 0, 2'd1, 1, 32'h12, 32'h0, r, e);
        n_total++;
        if (r !== 32'h00008001) $display("FAIL lhu_const: got %h want 00008001", r);
        else n_pass++;
        do_access("lw_13", 0, 2'd2, 0, 32'h13, 32'h0, r, e);
`ifdef MISALIGN_TRAP_EN
        n_total++;
        if (e !== 1'b1 || r !== 32'h0) $display("FAIL lw13_const: got err=%b rd=%h want 1 0", e, r);
        else n_pass++;
`else
        n_total++;
        if (e !== 1'b0 || r !== 32'h8001AA44) $display("FAIL lw13_const: got err=%b rd=%h want 0 8001AA44", e, r);
        else n_pass++;
`endif
        do_access("sw_oor", 1, 2'd2, 0, NW * 4, 32'h12345678, r, e);
        n_total++;
        if (e !== 1'b1) $display("FAIL oor_const: got err=%b want 1", e);
        else n_pass++;
        do_access("sz3", 1, 2'd3, 0, 32'h20, 32'h12345678, r, e);
        n_total++;
        if (e !== 1'b1) $display("FAIL sz3_const: got err=%b want 1", e);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        e;
        for (int i = 0; i < 150; i++) begin
            do_access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom_range(0, NW * 4 + 31),
                      $urandom, r, e);
        end
    endtask

    task automatic test_reset_in_wr();
        int k;
        preload(8, 32'hCAFEF00D);
        @(negedge clk);
        is_store = 1; size = 2'd0; is_unsigned = 0; addr = 32'h21; wdata = 32'h55;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        k = 0;
        while (mem_we !== 1'b1 && k < 6) begin
            @(posedge clk);
            #1 k++;
        end
        n_total++;
        if (mem_we !== 1'b1) $display("FAIL rst_wr_reach: got we=%b want 1", mem_we);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (mem_we !== 1'b0) $display("FAIL rst_wr_drop: got we=%b want 0", mem_we);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (mem[8] !== 32'hCAFEF00D) $display("FAIL rst_wr_mem: got %h want CAFEF00D", mem[8]);
        else n_pass++;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_held_req();
        logic        fa, fb;
        logic [31:0] ra, rb;
        int          la, lb, k;
        preload(9, $urandom);
        preload(10, $urandom);
        model(0, 2'd2, 0, 32'h24, 32'h0, fa, ra, la);
        model(0, 2'd0, 1, 32'h2A, 32'h0, fb, rb, lb);
        dq.delete();
        @(negedge clk);
        is_store = 0; size = 2'd2; is_unsigned = 0; addr = 32'h24;
        req = 1'b1;
        @(posedge clk);
        #1;
        size = 2'd0; is_unsigned = 1; addr = 32'h2A;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_total++;
        if (dq.size() != 2) $display("FAIL held_count: got %0d dones want 2", dq.size());
        else n_pass++;
        if (dq.size() >= 2) begin
            n_total++;
            if (dq[0] !== ra || dq[1] !== rb)
                $display("FAIL held_data: got %h %h want %h %h", dq[0], dq[1], ra, rb);
            else n_pass++;
        end
    endtask

    initial begin
        req = 1'b0; is_store = 1'b0; size = 2'd0; is_unsigned = 1'b0;
        addr = '0; wdata = 32'h0;
        test_reset();
        for (int i = 0; i < NW; i++) preload(i, $urandom);
        test_directed();
        test_random();
        test_reset_in_wr();
        test_held_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
